// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter slice: default widths,
// load-extension mode codes and the round-robin pointer helper.
package wb_pkg;

  localparam int unsigned DEF_NUM_SRC = 2;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_ADDR_W  = 5;
  localparam int unsigned LDMODE_W    = 3;
  localparam int unsigned BOFF_W      = 2;

  localparam logic [LDMODE_W-1:0] LDMODE_WORD = 3'b000;
  localparam logic [LDMODE_W-1:0] LDMODE_LBU  = 3'b001;
  localparam logic [LDMODE_W-1:0] LDMODE_LB   = 3'b010;
  localparam logic [LDMODE_W-1:0] LDMODE_LHU  = 3'b011;
  localparam logic [LDMODE_W-1:0] LDMODE_LH   = 3'b100;

  // Index following idx in a ring of n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return ((idx + 1) >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load-data extension.
// Ports: d (raw word), mode (LDMODE_* code), boff (byte offset) -> ext_data.
// Half modes select the half by boff[1]; unknown codes pass the word through.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0]   d,
  input  logic [LDMODE_W-1:0] mode,
  input  logic [BOFF_W-1:0]   boff,
  output logic [DATA_W-1:0]   ext_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = d[{boff, 3'b000} +: 8];
  assign sel_half = d[{boff[1], 4'b0000} +: 16];

  // Mode decode.
  always_comb begin
    ext_data = d;
    case (mode)
      LDMODE_LBU: ext_data = DATA_W'(sel_byte);
      LDMODE_LB:  ext_data = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
      LDMODE_LHU: ext_data = DATA_W'(sel_half);
      LDMODE_LH:  ext_data = {{(DATA_W-16){sel_half[15]}}, sel_half};
      default:    ext_data = d;
    endcase
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter: merges NUM_SRC result producers into the
// single GRF write port through one registered slot that also feeds
// W-stage forwarding.
// Ports: clk, reset (async active-low); src_valid/src_ready handshake plus
// per-source addr/data/ldmode/boff; grf_ready back-pressure; grf_we/wa/wd
// write port; fwd_valid/addr/data forwarding view of the slot.
// Optional: define WB_BYPASS_EN to let a transfer into an empty slot with
// grf_ready=1 write through in the same cycle.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [NUM_SRC-1:0]           src_ready,
  input  logic [NUM_SRC*ADDR_W-1:0]    src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]    src_data,
  input  logic [NUM_SRC*LDMODE_W-1:0]  src_ldmode,
  input  logic [NUM_SRC*BOFF_W-1:0]    src_boff,
  input  logic                         grf_ready,
  output logic                         grf_we,
  output logic [ADDR_W-1:0]            grf_wa,
  output logic [DATA_W-1:0]            grf_wd,
  output logic                         fwd_valid,
  output logic [ADDR_W-1:0]            fwd_addr,
  output logic [DATA_W-1:0]            fwd_data
);

  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic                full_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [SRC_W-1:0]    rr_ptr;

  logic                grant_found;
  logic [SRC_W-1:0]    grant_idx;
  int unsigned         scan_idx;
  logic                accept;
  logic                bypass_c;

  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_data;
  logic [LDMODE_W-1:0] g_mode;
  logic [BOFF_W-1:0]   g_boff;
  logic [DATA_W-1:0]   g_ext;
  logic [DATA_W-1:0]   g_wd;

  // First valid source scanning up from rr_ptr with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      scan_idx = 32'(rr_ptr) + i;
      if (scan_idx >= NUM_SRC) scan_idx = scan_idx - NUM_SRC;
      if (!grant_found && src_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = SRC_W'(scan_idx);
      end
    end
  end

  // Ready only to the granted source, only when the slot can take it.
  assign accept    = grant_found & (!full_q | grf_ready) & reset;
  assign src_ready = accept ? (NUM_SRC'(1) << grant_idx) : '0;

  assign g_addr = src_addr[32'(grant_idx)*ADDR_W +: ADDR_W];
  assign g_data = src_data[32'(grant_idx)*DATA_W +: DATA_W];
  assign g_mode = src_ldmode[32'(grant_idx)*LDMODE_W +: LDMODE_W];
  assign g_boff = src_boff[32'(grant_idx)*BOFF_W +: BOFF_W];

  wb_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .d        (g_data),
    .mode     (g_mode),
    .boff     (g_boff),
    .ext_data (g_ext)
  );

  // Address-0 writes are discarded, so their data is zeroed at capture.
  assign g_wd = (g_addr != '0) ? g_ext : '0;

`ifdef WB_BYPASS_EN
  assign bypass_c = accept & !full_q & grf_ready;
`else
  assign bypass_c = 1'b0;
`endif

  // Slot and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      rr_ptr <= '0;
    end else begin
      if (accept) rr_ptr <= SRC_W'(rr_next(32'(grant_idx), NUM_SRC));
      if (accept && !bypass_c) begin
        full_q <= 1'b1;
        we_q   <= (g_addr != '0);
        addr_q <= g_addr;
        data_q <= g_wd;
      end else if (grf_ready) begin
        full_q <= 1'b0;
        we_q   <= 1'b0;
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Write-through view of the granted request while the slot stays empty.
  assign grf_we    = bypass_c ? (g_addr != '0) : we_q;
  assign grf_wa    = bypass_c ? g_addr : addr_q;
  assign grf_wd    = bypass_c ? g_wd   : data_q;
  assign fwd_valid = grf_we;
  assign fwd_addr  = grf_wa;
  assign fwd_data  = grf_wd;
`else
  assign grf_we    = we_q;
  assign grf_wa    = addr_q;
  assign grf_wd    = data_q;
  assign fwd_valid = we_q;
  assign fwd_addr  = addr_q;
  assign fwd_data  = data_q;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter (default build, registered slot).
module tb_writeback_arbiter;

  localparam int N  = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk;
  logic            reset;
  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_ready;
  logic [N*AW-1:0] src_addr;
  logic [N*DW-1:0] src_data;
  logic [N*3-1:0]  src_ldmode;
  logic [N*2-1:0]  src_boff;
  logic            grf_ready;
  logic            grf_we;
  logic [AW-1:0]   grf_wa;
  logic [DW-1:0]   grf_wd;
  logic            fwd_valid;
  logic [AW-1:0]   fwd_addr;
  logic [DW-1:0]   fwd_data;

  int errors = 0;
  int checks = 0;

  writeback_arbiter #(.NUM_SRC(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_addr   (src_addr),
    .src_data   (src_data),
    .src_ldmode (src_ldmode),
    .src_boff   (src_boff),
    .grf_ready  (grf_ready),
    .grf_we     (grf_we),
    .grf_wa     (grf_wa),
    .grf_wd     (grf_wd),
    .fwd_valid  (fwd_valid),
    .fwd_addr   (fwd_addr),
    .fwd_data   (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference load extension computed with shifts and masks.
  function automatic logic [31:0] ref_ext(input logic [31:0] d, input int mode, input int boff);
    logic [31:0] b, h;
    b = (d >> (8 * boff)) & 32'hFF;
    h = (d >> (16 * (boff / 2))) & 32'hFFFF;
    case (mode)
      1:       return b;
      2:       return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3:       return h;
      4:       return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      default: return d;
    endcase
  endfunction

  task automatic set_src(input int i, input logic [4:0] a, input logic [31:0] d,
                         input logic [2:0] m, input logic [1:0] bo);
    src_addr[i*AW +: AW]   = a;
    src_data[i*DW +: DW]   = d;
    src_ldmode[i*3 +: 3]   = m;
    src_boff[i*2 +: 2]     = bo;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    src_valid = '0;
    grf_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    src_valid = 2'b11;
    grf_ready = 1'b1;
    set_src(0, 5'd4, 32'h1111_1111, 3'd0, 2'd0);
    set_src(1, 5'd5, 32'h2222_2222, 3'd0, 2'd0);
    @(negedge clk);
    checks++; if (src_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", src_ready); end
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", grf_we); end
    checks++; if (grf_wa !== 5'd0 || grf_wd !== 32'd0) begin errors++; $display("FAIL reset_wawd got %h/%h exp 0/0", grf_wa, grf_wd); end
    checks++; if (fwd_valid !== 1'b0 || fwd_addr !== 5'd0 || fwd_data !== 32'd0) begin
      errors++; $display("FAIL reset_fwd got %b/%h/%h exp 0/0/0", fwd_valid, fwd_addr, fwd_data); end
  endtask

  task automatic test_single();
    do_reset();
    set_src(0, 5'd8, 32'h1234_5678, 3'd0, 2'd0);
    src_valid = 2'b01;
    grf_ready = 1'b1;
    @(negedge clk);
    checks++; if (src_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", src_ready); end
    @(posedge clk); #1;
    src_valid = '0;
    @(negedge clk);
    checks++; if (grf_we !== 1'b1 || grf_wa !== 5'd8 || grf_wd !== 32'h1234_5678) begin
      errors++; $display("FAIL single_write got %b/%h/%h exp 1/08/12345678", grf_we, grf_wa, grf_wd); end
    checks++; if (fwd_valid !== 1'b1 || fwd_addr !== 5'd8 || fwd_data !== 32'h1234_5678) begin
      errors++; $display("FAIL single_fwd got %b/%h/%h exp 1/08/12345678", fwd_valid, fwd_addr, fwd_data); end
  endtask

  task automatic test_alternate();
    do_reset();
    set_src(0, 5'd1, 32'hA0A0_0001, 3'd0, 2'd0);
    set_src(1, 5'd2, 32'hB0B0_0002, 3'd0, 2'd0);
    src_valid = 2'b11;
    grf_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (src_ready !== 2'(1 << (k % 2))) begin
        errors++; $display("FAIL alt_grant%0d got %b exp %b", k, src_ready, 2'(1 << (k % 2))); end
      if (k > 0) begin
        checks++; if (grf_we !== 1'b1 || grf_wa !== 5'((k - 1) % 2 + 1)) begin
          errors++; $display("FAIL alt_write%0d got %b/%h exp 1/%h", k, grf_we, grf_wa, 5'((k - 1) % 2 + 1)); end
      end
      @(posedge clk); #1;
    end
    src_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_src(0, 5'd5, 32'hAAAA_0005, 3'd0, 2'd0);
    set_src(1, 5'd6, 32'hBBBB_0006, 3'd0, 2'd0);
    src_valid = 2'b11;
    grf_ready = 1'b1;
    @(posedge clk); #1;
    grf_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (src_ready !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got %b exp 00", k, src_ready); end
      checks++; if (grf_we !== 1'b1 || grf_wa !== 5'd5 || grf_wd !== 32'hAAAA_0005) begin
        errors++; $display("FAIL bp_hold%0d got %b/%h/%h exp 1/05/aaaa0005", k, grf_we, grf_wa, grf_wd); end
      @(posedge clk); #1;
    end
    grf_ready = 1'b1;
    @(negedge clk);
    checks++; if (src_ready !== 2'b10) begin errors++; $display("FAIL bp_next_grant got %b exp 10", src_ready); end
    @(posedge clk); #1;
    src_valid = '0;
    @(negedge clk);
    checks++; if (grf_wa !== 5'd6 || grf_wd !== 32'hBBBB_0006) begin
      errors++; $display("FAIL bp_drain got %h/%h exp 06/bbbb0006", grf_wa, grf_wd); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  modes [4] = '{3'b010, 3'b001, 3'b100, 3'b011};
    logic [1:0]  boffs [4] = '{2'd3, 2'd3, 2'd2, 2'd0};
    logic [31:0] exps  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
    do_reset();
    grf_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_src(0, 5'd3, 32'h80FF_7F01, modes[k], boffs[k]);
      src_valid = 2'b01;
      @(posedge clk); #1;
      src_valid = '0;
      @(negedge clk);
      checks++; if (grf_we !== 1'b1 || grf_wd !== exps[k]) begin
        errors++; $display("FAIL ldext%0d got %b/%h exp 1/%h", k, grf_we, grf_wd, exps[k]); end
    end
  endtask

  task automatic test_addr_zero();
    do_reset();
    set_src(0, 5'd0, 32'hDEAD_BEEF, 3'd0, 2'd0);
    set_src(1, 5'd9, 32'h0000_0009, 3'd0, 2'd0);
    src_valid = 2'b01;
    grf_ready = 1'b1;
    @(negedge clk);
    checks++; if (src_ready !== 2'b01) begin errors++; $display("FAIL a0_accept got %b exp 01", src_ready); end
    @(posedge clk); #1;
    src_valid = 2'b11;
    @(negedge clk);
    checks++; if (grf_we !== 1'b0 || grf_wd !== 32'd0 || fwd_valid !== 1'b0) begin
      errors++; $display("FAIL a0_suppress got %b/%h/%b exp 0/0/0", grf_we, grf_wd, fwd_valid); end
    checks++; if (src_ready !== 2'b10) begin errors++; $display("FAIL a0_rr_adv got %b exp 10", src_ready); end
    @(posedge clk); #1;
    src_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_src(0, 5'd10, 32'h0A0A_0A0A, 3'd0, 2'd0);
    set_src(1, 5'd11, 32'h0B0B_0B0B, 3'd0, 2'd0);
    src_valid = 2'b11;
    grf_ready = 1'b1;
    @(posedge clk); #1;
    grf_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (grf_we !== 1'b0 || grf_wa !== 5'd0 || grf_wd !== 32'd0 || fwd_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_out got %b/%h/%h/%b exp 0/0/0/0", grf_we, grf_wa, grf_wd, fwd_valid); end
    checks++; if (src_ready !== 2'b00) begin errors++; $display("FAIL midrst_ready got %b exp 00", src_ready); end
    #2 reset = 1'b1;
    grf_ready = 1'b1;
    #1;
    checks++; if (src_ready !== 2'b01) begin errors++; $display("FAIL midrst_first got %b exp 01", src_ready); end
    @(posedge clk); #1;
    src_valid = '0;
  endtask

  task automatic test_random();
    bit          m_full = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    int          m_rr   = 0;
    int          g;
    logic [N-1:0] exp_ready;
    logic [4:0]  a [N];
    logic [31:0] d [N];
    logic [2:0]  m [N];
    logic [1:0]  bo [N];
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        a[i]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        d[i]  = $urandom;
        m[i]  = 3'($urandom_range(0, 7));
        bo[i] = 2'($urandom_range(0, 3));
        set_src(i, a[i], d[i], m[i], bo[i]);
      end
      src_valid = N'($urandom);
      grf_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      // Expected grant: first valid from the pointer, if the slot can accept.
      g = -1;
      if (!m_full || grf_ready)
        for (int i = 0; i < N; i++)
          if (g < 0 && src_valid[(m_rr + i) % N]) g = (m_rr + i) % N;
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      checks++; if (src_ready !== exp_ready) begin
        errors++; $display("FAIL rnd_ready c%0d got %b exp %b", cyc, src_ready, exp_ready); end
      checks++; if (grf_we !== (m_full && m_addr != 0) || fwd_valid !== (m_full && m_addr != 0)) begin
        errors++; $display("FAIL rnd_we c%0d got %b/%b exp %b", cyc, grf_we, fwd_valid, m_full && m_addr != 0); end
      if (m_full) begin
        checks++; if (grf_wa !== m_addr || grf_wd !== m_data || fwd_data !== m_data) begin
          errors++; $display("FAIL rnd_slot c%0d got %h/%h exp %h/%h", cyc, grf_wa, grf_wd, m_addr, m_data); end
      end
      if (g >= 0) begin
        m_full = 1'b1;
        m_addr = a[g];
        m_data = (a[g] != 0) ? ref_ext(d[g], int'(m[g]), int'(bo[g])) : 32'd0;
        m_rr   = (g + 1) % N;
      end else if (grf_ready) begin
        m_full = 1'b0;
      end
      @(posedge clk); #1;
    end
    src_valid = '0;
  endtask

  initial begin
    reset = 1'b0;
    src_valid = '0;
    src_addr = '0;
    src_data = '0;
    src_ldmode = '0;
    src_boff = '0;
    grf_ready = 1'b0;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_load_ext();
    test_addr_zero();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Parametrised writeback stage for the pipelined MIPS core.
- Merges NUM_SRC independent result producers into the single GRF write port, for example the in-order pipe (ALU/DM/PC+8) and the multi-cycle MDU (HI/LO moves).
- Performs load-data extension per request.
- Holds one registered writeback slot that is also the W-stage forwarding source.
- Arbitration is round-robin with valid/ready handshakes on both sides.

Parameters:
- NUM_SRC, 2, number of writeback requesters (1..8).
- DATA_W, 32, register data width.
- ADDR_W, 5, GRF address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- src_valid  in  NUM_SRC  request valid, one bit per source.
- src_ready  out  NUM_SRC  grant/accept, one bit per source.
- src_addr  in  NUM_SRC*ADDR_W  destination register per source; source i occupies bits [i*ADDR_W +: ADDR_W].
- src_data  in  NUM_SRC*DATA_W  raw result or DM word per source.
- src_ldmode  in  NUM_SRC*3  extension mode per source.
- src_boff  in  NUM_SRC*2  byte offset of the load within the word.
- grf_ready  in  1  GRF or consumer can take the slot this cycle.
- grf_we  out  1  write enable to the GRF.
- grf_wa  out  ADDR_W  GRF write address.
- grf_wd  out  DATA_W  GRF write data.
- fwd_valid  out  1  forwarding slot holds a live nonzero-address write.
- fwd_addr  out  ADDR_W  forwarding address.
- fwd_data  out  DATA_W  forwarding data.

Behaviour:
- Reset (reset=0, asynchronous)
  - Slot empty; grf_we=0, grf_wa=0, grf_wd=0.
  - fwd_valid=0, fwd_addr=0, fwd_data=0.
  - Round-robin pointer rr_ptr=0.
  - src_ready=0 while reset is asserted.
  - Asserting reset mid-transfer discards the slot content; no write occurs.
- Slot occupancy
  - The slot is a single register stage: one full bit plus addr and data.
  - can_accept = !full | grf_ready.
- Arbitration (combinational)
  - Scan sources starting at rr_ptr, wrapping modulo NUM_SRC.
  - The first source with src_valid=1 is granted.
  - src_ready[g]=can_accept for the granted source g; all other src_ready bits are 0.
  - With no valid source, all src_ready=0.
- Transfer
  - A transfer completes when src_valid[g] & src_ready[g].
  - On the next edge the slot loads addr=src_addr[g] and data=ext(src_data[g]), and full=1.
  - rr_ptr <= (g+1) mod NUM_SRC.
  - rr_ptr holds when no transfer occurs.
- Drain
  - If full & grf_ready and there is no new transfer, full becomes 0 at the next edge.
  - Drain and refill in the same cycle is allowed, giving one write per cycle sustained.
- Latency
  - One cycle from accept to grf_we.
- Output
  - grf_we = full & (addr != 0).
  - grf_wa and grf_wd drive the slot contents.
  - Address-0 requests are accepted and consume a slot cycle, but grf_we stays 0 and grf_wd is forced to 0.
- Back-pressure
  - While full & !grf_ready, the slot and rr_ptr hold, and all src_ready=0.
- Forwarding
  - fwd_valid = full & (addr != 0).
  - fwd_addr and fwd_data mirror the slot.
- Extension ext(d, mode, boff), applied to the byte/half selected by boff:
  - 000: word, pass through.
  - 001: lbu, zero-extend the selected byte.
  - 010: lb, sign-extend the selected byte.
  - 011: lhu, zero-extend the half at boff[1].
  - 100: lh, sign-extend the half at boff[1].
  - Other codes: pass through.
  - boff[0] is ignored for half modes.
- Simultaneous requests to the same register are serialised in grant order; the later grant wins in the GRF.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - When the slot is empty and a transfer completes in the same cycle as grf_ready=1, the extended data writes through combinationally.
  - grf_we/grf_wa/grf_wd and fwd_* reflect the granted request in that cycle and the slot stays empty, giving 0-cycle latency.
  - Back-pressured or full cases behave as without the macro.
- Undefined:
  - Always registered; 1-cycle latency.

Decomposition:
- Package wb_pkg
  - LDMODE_* constants for codes 000..100.
  - Default widths.
  - Function for the round-robin next index.
- Sub-module wb_load_ext: purely combinational extension (d, mode, boff -> extended data). It is instantiated once, on the granted request.

Test Plan:
- Single source 0 valid, addr=8, data=0x1234_5678, mode=000, grf_ready=1 -> src_ready[0]=1; next cycle grf_we=1, wa=8, wd=0x1234_5678, fwd_valid=1.
- Both sources valid every cycle, grf_ready=1, rr_ptr=0 after reset -> grants alternate 0,1,0,1; one write per cycle, no bubbles.
- Slot full, grf_ready=0 for 3 cycles -> src_ready=0, outputs stable; on grf_ready=1 the slot drains and the next grant follows rr_ptr.
- Load extension with data=0x80FF_7F01:
  - lb, boff=3 -> wd=0xFFFF_FF80.
  - lbu, boff=3 -> wd=0x0000_0080.
  - lh, boff=2 -> wd=0xFFFF_80FF.
  - lhu, boff=0 -> wd=0x0000_7F01.
- Request with addr=0, data=0xDEAD_BEEF -> accepted, grf_we=0, grf_wd=0, fwd_valid=0, rr_ptr advances.
- Reset pulled low while full with a pending grant -> outputs and rr_ptr zero immediately; after release the first grant goes to source 0.
